minuteur_prescale: RTL and testbench

MINUTEUR_PRESCALE -- requirements
Module: minuteur_prescale

---
 rtl/minuteur_prescale.sv | 131 +++++++++++++
 tb/tb_minuteur_prescale.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/minuteur_prescale.sv
// Down-counting timer with a tick prescaler, one-shot or periodic reload,
// pause/abort control and a registered expiry pulse.
module minuteur_prescale #(
   parameter int unsigned WIDTH    = 9,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             timer_start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   input  logic             timer_abort,
   input  logic             timer_pause,
   input  logic             timer_tick,
   output logic [WIDTH-1:0] count,
   output logic             timer_up,
   output logic             timer_expire,
   output logic             busy
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] count_nx;
   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] reload_nx;
   logic             mode_reg;
   logic             mode_nx;
   logic [PW-1:0]    presc_cnt;
   logic [PW-1:0]    presc_nx;
   logic             expire_nx;
   logic             dec_ev;

   // State and datapath registers; outputs are derived from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         count        <= '1;
         reload_reg   <= '1;
         mode_reg     <= 1'b0;
         presc_cnt    <= '0;
         timer_up     <= 1'b0;
         timer_expire <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         count        <= count_nx;
         reload_reg   <= reload_nx;
         mode_reg     <= mode_nx;
         presc_cnt    <= presc_nx;
         timer_up     <= (state_nx == S_DONE);
         timer_expire <= expire_nx;
         busy         <= (state_nx == S_RUN) || (state_nx == S_PAUSE);
      end
   end

   // Next-state logic: start > abort > pause > tick
   always_comb begin
      state_nx  = state;
      count_nx  = count;
      reload_nx = reload_reg;
      mode_nx   = mode_reg;
      presc_nx  = presc_cnt;
      expire_nx = 1'b0;
      dec_ev    = 1'b0;

      if (timer_start) begin
         count_nx  = load_val;
         reload_nx = load_val;
         mode_nx   = auto_reload;
         presc_nx  = '0;
         if (load_val == '0) begin
            state_nx  = S_DONE;
            expire_nx = 1'b1;
         end else begin
            state_nx = S_RUN;
         end
      end else if (timer_abort) begin
         state_nx = S_IDLE;
         presc_nx = '0;
      end else begin
         case (state)
            S_RUN: begin
               if (timer_pause) begin
                  state_nx = S_PAUSE;
               end else if (timer_tick) begin
                  if (presc_cnt == PRESC_LAST) begin
                     presc_nx = '0;
                     dec_ev   = 1'b1;
                  end else begin
                     presc_nx = presc_cnt + PW'(1);
                  end
               end
            end
            S_PAUSE: begin
               if (!timer_pause) begin
                  state_nx = S_RUN;
               end
            end
            default: begin
            end
         endcase

         // A zero count in RUN cannot arise, but it is held rather than wrapped
         if (dec_ev) begin
            if (count > ONE) begin
               count_nx = count - ONE;
            end else if (count == ONE) begin
               expire_nx = 1'b1;
               if (mode_reg) begin
                  count_nx = reload_reg;
               end else begin
                  count_nx = '0;
                  state_nx = S_DONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_minuteur_prescale.sv
// Directed bench for minuteur_prescale: a PRESCALE=1 and a PRESCALE=3 instance
// share stimulus; each scenario checks the instance it targets.
module tb_minuteur_prescale;

   logic       clk;
   logic       reset;
   logic       timer_start;
   logic [8:0] load_val;
   logic       auto_reload;
   logic       timer_abort;
   logic       timer_pause;
   logic       timer_tick;

   logic [8:0] count1, count3;
   logic       up1, up3, exp1, exp3, busy1, busy3;

   int checks = 0;
   int errors = 0;

   minuteur_prescale #(.WIDTH(9), .PRESCALE(1)) u_dut1 (
      .clk(clk), .reset(reset), .timer_start(timer_start), .load_val(load_val),
      .auto_reload(auto_reload), .timer_abort(timer_abort), .timer_pause(timer_pause),
      .timer_tick(timer_tick), .count(count1), .timer_up(up1),
      .timer_expire(exp1), .busy(busy1)
   );

   minuteur_prescale #(.WIDTH(9), .PRESCALE(3)) u_dut3 (
      .clk(clk), .reset(reset), .timer_start(timer_start), .load_val(load_val),
      .auto_reload(auto_reload), .timer_abort(timer_abort), .timer_pause(timer_pause),
      .timer_tick(timer_tick), .count(count3), .timer_up(up3),
      .timer_expire(exp3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock with the given pulses; outputs are sampled 1 time unit after the edge
   task automatic step(input logic st, input logic ab, input logic pa, input logic tk);
      timer_start = st;
      timer_abort = ab;
      timer_pause = pa;
      timer_tick  = tk;
      @(posedge clk);
      #1;
      timer_start = 1'b0;
      timer_abort = 1'b0;
      timer_tick  = 1'b0;
   endtask

   task automatic start(input logic [8:0] v, input logic ar);
      load_val    = v;
      auto_reload = ar;
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [8:0] seq34 [6];
      logic       exp34 [6];
      int         pulses;

      reset       = 1'b1;
      timer_start = 1'b0;
      load_val    = '0;
      auto_reload = 1'b0;
      timer_abort = 1'b0;
      timer_pause = 1'b0;
      timer_tick  = 1'b0;
      @(posedge clk);
      #1;

      // Reset state and ticks in IDLE
      chk("rst_count", 32'(count1), 32'd511);
      chk("rst_up", 32'(up1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_expire", 32'(exp1), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("idle_ticks_count", 32'(count1), 32'd511);
      chk("idle_ticks_busy", 32'(busy1), 32'd0);

      // One-shot, load 3
      start(9'd3, 1'b0);
      chk("os_load", 32'(count1), 32'd3);
      chk("os_busy", 32'(busy1), 32'd1);
      chk("os_exp0", 32'(exp1), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("os_t1", 32'(count1), 32'd2);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("os_t2", 32'(count1), 32'd1);
      chk("os_t2_exp", 32'(exp1), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("os_t3", 32'(count1), 32'd0);
      chk("os_t3_exp", 32'(exp1), 32'd1);
      chk("os_t3_up", 32'(up1), 32'd1);
      chk("os_t3_busy", 32'(busy1), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("os_exp_drop", 32'(exp1), 32'd0);
      chk("os_up_hold", 32'(up1), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("os_nowrap", 32'(count1), 32'd0);
      chk("os_up_after", 32'(up1), 32'd1);

      // PRESCALE=3, load 2: decrements after ticks 3 and 6
      start(9'd2, 1'b0);
      chk("p3_load", 32'(count3), 32'd2);
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk($sformatf("p3_tick%0d", i), 32'(count3), (i < 3) ? 32'd2 : (i < 6) ? 32'd1 : 32'd0);
         chk($sformatf("p3_up%0d", i), 32'(up3), (i == 6) ? 32'd1 : 32'd0);
         chk($sformatf("p3_exp%0d", i), 32'(exp3), (i == 6) ? 32'd1 : 32'd0);
      end

      // Periodic, load 2
      seq34 = '{9'd1, 9'd2, 9'd1, 9'd2, 9'd1, 9'd2};
      exp34 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      pulses = 0;
      start(9'd2, 1'b1);
      chk("ar_load", 32'(count1), 32'd2);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         if (exp1 === 1'b1) pulses++;
         chk($sformatf("ar_count%0d", i), 32'(count1), 32'(seq34[i]));
         chk($sformatf("ar_exp%0d", i), 32'(exp1), 32'(exp34[i]));
         chk($sformatf("ar_up%0d", i), 32'(up1), 32'd0);
         chk($sformatf("ar_busy%0d", i), 32'(busy1), 32'd1);
      end
      chk("ar_pulses", 32'(pulses), 32'd3);

      // Pause: load 5, 2 ticks, 4 paused ticks, release, 3 ticks
      start(9'd5, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("pz_pre", 32'(count1), 32'd3);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("pz_held", 32'(count1), 32'd3);
      chk("pz_busy", 32'(busy1), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pz_resume", 32'(count1), 32'd3);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("pz_t1", 32'(count1), 32'd2);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("pz_t2", 32'(count1), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("pz_t3", 32'(count1), 32'd0);
      chk("pz_up", 32'(up1), 32'd1);
      chk("pz_exp", 32'(exp1), 32'd1);

      // Start beats abort; abort holds count; load 0 goes straight to DONE
      load_val = 9'd4;
      auto_reload = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("sa_count", 32'(count1), 32'd4);
      chk("sa_busy", 32'(busy1), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("ab_count", 32'(count1), 32'd4);
      chk("ab_busy", 32'(busy1), 32'd0);
      chk("ab_up", 32'(up1), 32'd0);
      chk("ab_exp", 32'(exp1), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ab_exp_later", 32'(exp1), 32'd0);
      chk("ab_idle_tick", 32'(count1), 32'd4);
      start(9'd0, 1'b1);
      chk("z_count", 32'(count1), 32'd0);
      chk("z_up", 32'(up1), 32'd1);
      chk("z_exp", 32'(exp1), 32'd1);
      chk("z_busy", 32'(busy1), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("z_exp_drop", 32'(exp1), 32'd0);
      chk("z_up_hold", 32'(up1), 32'd1);

      // Asynchronous reset mid-run
      start(9'd7, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("mr_pre", 32'(count1), 32'd6);
      #2;
      reset = 1'b1;
      #1;
      chk("mr_async_count", 32'(count1), 32'd511);
      chk("mr_async_busy", 32'(busy1), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("mr_after_count", 32'(count1), 32'd511);
      chk("mr_after_busy", 32'(busy1), 32'd0);
      chk("mr_after_up", 32'(up1), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
